// File: rtl/demux_pkg.sv
// Shared constants and the queued write-request record for the 64-bit 1:8
// write demux with its in-order write buffer.
//   WIDTH : data width of each holding register
//   NREG  : number of holding registers (power of 2)
//   SELW  : register select width
//   DEPTH : write-FIFO entries (power of 2, >= 2)
//   PTRW  : FIFO pointer width, wraps naturally at DEPTH
//   CNTW  : occupancy counter width, holds 0..DEPTH
package demux_pkg;

    localparam int WIDTH = 64;
    localparam int NREG  = 8;
    localparam int SELW  = $clog2(NREG);
    localparam int DEPTH = 2;
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = PTRW + 1;

    typedef struct packed {
        logic [SELW-1:0]  sel;
        logic [WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/dec3_8.sv
// One-hot decoder with enable: onehot_o[i] = en_i & (sel_i == i).
// Ports:
//   en_i     : decoder enable, all outputs low when 0
//   sel_i    : binary index
//   onehot_o : one-hot decode of sel_i
module dec3_8 #(
    parameter int SELW = 3,
    parameter int NREG = 8
) (
    input  logic            en_i,
    input  logic [SELW-1:0] sel_i,
    output logic [NREG-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NREG; i++) begin
            onehot_o[i] = en_i & (sel_i == SELW'(i));
        end
    end

endmodule

// File: rtl/demux64_1x8_wbuf.sv
// Write-side demux for the 64-bit 8:1 read mux. Write requests (sel, data) are
// queued in a small in-order FIFO and drained one per cycle into eight 64-bit
// holding registers whose packed contents feed the read mux inputs directly.
// Ports:
//   clk, rst_n : rising-edge clock, async active-low reset
//   wr_valid   : write request valid
//   wr_ready   : FIFO can accept; a transfer is wr_valid & wr_ready
//   wr_sel     : destination register index
//   wr_data    : write data
//   hold       : stall, no FIFO drain this cycle
//   flush      : synchronous discard of all queued writes (bank untouched)
//   Q          : packed bank, Q[i*WIDTH +: WIDTH] = register i
//   pend       : pend[i] = 1 while a queued entry targets register i
//   count      : FIFO occupancy
//
// Handshake: a write transfers on a rising edge where wr_valid & wr_ready;
// wr_ready depends only on occupancy and flush, never on wr_valid, and the
// producer must hold wr_sel/wr_data stable while wr_valid waits for wr_ready.
module demux64_1x8_wbuf
    import demux_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SELW-1:0]       wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  hold,
    input  logic                  flush,
    output logic [NREG*WIDTH-1:0] Q,
    output logic [NREG-1:0]       pend,
    output logic [CNTW-1:0]       count
);

    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    wr_req_t          fifo_q [DEPTH];
    logic [PTRW-1:0]  head_q, head_d;
    logic [PTRW-1:0]  tail_q, tail_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] bank_q [NREG];

    logic             push;
    logic             drain;
    wr_req_t          head_req;
    logic [NREG-1:0]  bank_we;
    logic [DEPTH-1:0] entry_valid;
    logic [NREG-1:0]  entry_onehot [DEPTH];

    assign wr_ready = (count_q < DEPTH_C) & ~flush;
    assign push     = wr_valid & wr_ready;
    // flush suppresses the drain so the bank is left exactly as it was.
    assign drain    = (count_q != '0) & ~hold & ~flush;
    assign head_req = fifo_q[head_q];
    assign count    = count_q;

    // Pointer / occupancy next state; flush overrides push and drain.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push)  tail_d = tail_q + PTRW'(1);
            if (drain) head_d = head_q + PTRW'(1);
            case ({push, drain})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) fifo_q[j] <= '0;
        end else if (push) begin
            fifo_q[tail_q] <= '{sel: wr_sel, data: wr_data};
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    // Each live entry decodes its target, and the OR of those gives pend.
    for (genvar j = 0; j < DEPTH; j++) begin : g_entry
        localparam logic [PTRW-1:0] IDX = PTRW'(j);
        logic [PTRW-1:0] offs;
        assign offs           = IDX - head_q;
        assign entry_valid[j] = {1'b0, offs} < count_q;

        dec3_8 #(.SELW(SELW), .NREG(NREG)) u_pend_dec (
            .en_i     (entry_valid[j]),
            .sel_i    (fifo_q[j].sel),
            .onehot_o (entry_onehot[j])
        );
    end

    always_comb begin
        pend = '0;
        for (int j = 0; j < DEPTH; j++) pend = pend | entry_onehot[j];
    end

    dec3_8 #(.SELW(SELW), .NREG(NREG)) u_bank_dec (
        .en_i     (drain),
        .sel_i    (head_req.sel),
        .onehot_o (bank_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (bank_we[i]) bank_q[i] <= head_req.data;
            end
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_q
        assign Q[i*WIDTH +: WIDTH] = bank_q[i];
    end

endmodule

// File: tb/tb_demux64_1x8_wbuf.sv
module tb_demux64_1x8_wbuf;

  logic         clk;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [2:0]   wr_sel;
  logic [63:0]  wr_data;
  logic         hold;
  logic         flush;
  logic [511:0] q;
  logic [7:0]   pend;
  logic [1:0]   count;

  int n_checks;
  int n_fail;

  demux64_1x8_wbuf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .hold     (hold),
    .flush    (flush),
    .Q        (q),
    .pend     (pend),
    .count    (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  sel;
    logic [63:0] data;
    logic        hold;
    logic        flush;
    logic        exp_ready;  // before the edge
    logic [1:0]  exp_count;  // after the edge
    logic [7:0]  exp_pend;   // after the edge
    int          chk_reg;
    logic [63:0] exp_q;      // Q[chk_reg] after the edge
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic logic [63:0] reg_of(input int idx);
    return q[idx*64 +: 64];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [63:0] d,
                       input logic h, input logic f);
    wr_valid = v;
    wr_sel   = s;
    wr_data  = d;
    hold     = h;
    flush    = f;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 1'b0, 1'b0);

    // T1: reset asserted mid-cycle acts without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("t1_q", {63'd0, q != 512'd0}, 64'd0);
    chk("t1_pend", {56'd0, pend}, 64'd0);
    chk("t1_ready", {63'd0, wr_ready}, 64'd1);
    chk("t1_count", {62'd0, count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //          valid sel   data                     hold flush rdy cnt  pend  reg exp_q
    // T2 single write
    vecs[0]  = '{1'b1, 3'd5, 64'hDEAD_BEEF_0000_0005, 1'b0, 1'b0, 1'b1, 2'd1, 8'h20, 5, 64'd0};
    vecs[1]  = '{1'b0, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 5, 64'hDEAD_BEEF_0000_0005};
    // T3 fill under hold, full rejects, then release
    vecs[2]  = '{1'b1, 3'd1, 64'd1,                  1'b1, 1'b0, 1'b1, 2'd1, 8'h02, 1, 64'd0};
    vecs[3]  = '{1'b1, 3'd7, 64'd7,                  1'b1, 1'b0, 1'b1, 2'd2, 8'h82, 7, 64'd0};
    vecs[4]  = '{1'b1, 3'd2, 64'h99,                 1'b1, 1'b0, 1'b0, 2'd2, 8'h82, 2, 64'd0};
    vecs[5]  = '{1'b0, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b0, 2'd1, 8'h80, 1, 64'd1};
    vecs[6]  = '{1'b0, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 7, 64'd7};
    // T4 same-register ordering
    vecs[7]  = '{1'b1, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, 1'b1, 2'd1, 8'h08, 3, 64'd0};
    vecs[8]  = '{1'b1, 3'd3, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b0, 1'b1, 2'd1, 8'h08, 3, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[9]  = '{1'b0, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 3, 64'hBBBB_BBBB_BBBB_BBBB};
    vecs[10] = '{1'b0, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 2, 64'd0};
    // T5 flush with concurrent push, full and half-full cases
    vecs[11] = '{1'b1, 3'd0, 64'h11,                 1'b1, 1'b0, 1'b1, 2'd1, 8'h01, 0, 64'd0};
    vecs[12] = '{1'b1, 3'd6, 64'h66,                 1'b1, 1'b0, 1'b1, 2'd2, 8'h41, 6, 64'd0};
    vecs[13] = '{1'b1, 3'd4, 64'h44,                 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 4, 64'd0};
    vecs[14] = '{1'b1, 3'd0, 64'h12,                 1'b1, 1'b0, 1'b1, 2'd1, 8'h01, 0, 64'd0};
    vecs[15] = '{1'b1, 3'd4, 64'h44,                 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 0, 64'd0};
    vecs[16] = '{1'b0, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 4, 64'd0};
    vecs[17] = '{1'b0, 3'd0, 64'd0,                  1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 5, 64'hDEAD_BEEF_0000_0005};

    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      drive(vecs[v].valid, vecs[v].sel, vecs[v].data, vecs[v].hold, vecs[v].flush);
      #1;
      chk($sformatf("v%0d_ready", v), {63'd0, wr_ready}, {63'd0, vecs[v].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", v), {62'd0, count}, {62'd0, vecs[v].exp_count});
      chk($sformatf("v%0d_pend", v), {56'd0, pend}, {56'd0, vecs[v].exp_pend});
      chk($sformatf("v%0d_reg%0d", v, vecs[v].chk_reg), reg_of(vecs[v].chk_reg), vecs[v].exp_q);
    end

    // T6: streaming, one accept per cycle, occupancy stays at one
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, 3'(i % 8), 64'(i), 1'b0, 1'b0);
      #1;
      chk($sformatf("t6_ready%0d", i), {63'd0, wr_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("t6_count%0d", i), {62'd0, count}, 64'd1);
      if (i > 0) chk($sformatf("t6_prev%0d", i), reg_of((i - 1) % 8), 64'(i - 1));
    end
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("t6_count_end", {62'd0, count}, 64'd0);
    for (int j = 0; j < 8; j++) chk($sformatf("t6_reg%0d", j), reg_of(j), 64'(j + 8));

    // Reset mid-operation: queued write lost, bank cleared, no partial write
    @(negedge clk);
    drive(1'b1, 3'd2, 64'h5555, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("mr_pend_before", {56'd0, pend}, 64'h04);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_q", {63'd0, q != 512'd0}, 64'd0);
    chk("mr_pend", {56'd0, pend}, 64'd0);
    chk("mr_count", {62'd0, count}, 64'd0);
    chk("mr_ready", {63'd0, wr_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_reg2_after", reg_of(2), 64'd0);
    chk("mr_count_after", {62'd0, count}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
